// File: rtl/rom_arbiter.sv
// rom_arbiter
// Shares one asynchronous 512 KB ROM between two synchronous read requesters.
// Port 0 is the Z80 fetch path and port 1 is the loader/DMA path. When both
// request at once, grants alternate between them. Every access holds the ROM
// strobes low for WAIT_CYCLES cycles and is followed by one recovery cycle.
//
// State | meaning
// ------+-------------------------------------------------------------------
// IDLE  | strobes high; a request sampled here is granted
// ACCESS| strobes low; r_cnt counts down the remaining wait cycles
// DONE  | strobes high; the winner's ack is high for this one cycle
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   req0/addr0          port 0 request (level) and address
//   ack0/rdata0         port 0 completion pulse and read data
//   req1/addr1          port 1 request (level) and address
//   ack1/rdata1         port 1 completion pulse and read data
//   rom_a/rom_d         ROM address and data pins
//   rom_ce_n/rom_oe_n   ROM chip enable and output enable, active low
//   busy                high whenever the FSM is not in IDLE
module rom_arbiter #(
    parameter int WAIT_CYCLES = 3,
    parameter int AW          = 19
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic [7:0]    rdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          ack1,
    output logic [7:0]    rdata1,
    output logic [AW-1:0] rom_a,
    input  logic [7:0]    rom_d,
    output logic          rom_ce_n,
    output logic          rom_oe_n,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // The counter starts at WAIT_CYCLES-1 so that the terminal count of zero
    // lands on the last strobe-low cycle.
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t          r_state, w_state_nx;
    logic [3:0]      r_cnt, w_cnt_nx;
    logic            r_win, w_win_nx;
    logic            r_last, w_last_nx;
    logic [AW-1:0]   r_rom_a, w_rom_a_nx;
    logic            r_strobe_n, w_strobe_n_nx;
    logic            r_ack0, w_ack0_nx;
    logic            r_ack1, w_ack1_nx;
    logic [7:0]      r_rdata0, w_rdata0_nx;
    logic [7:0]      r_rdata1, w_rdata1_nx;
    logic            w_pick;

    // A lone request wins outright; on a tie the port not granted last wins.
    assign w_pick = (req0 && req1) ? ~r_last : req1;

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_win_nx      = r_win;
        w_last_nx     = r_last;
        w_rom_a_nx    = r_rom_a;
        w_strobe_n_nx = r_strobe_n;
        w_ack0_nx     = 1'b0;
        w_ack1_nx     = 1'b0;
        w_rdata0_nx   = r_rdata0;
        w_rdata1_nx   = r_rdata1;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_win_nx      = w_pick;
                    w_rom_a_nx    = w_pick ? addr1 : addr0;
                    w_strobe_n_nx = 1'b0;
                    w_cnt_nx      = CNT_INIT;
                    w_state_nx    = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nx = r_cnt - 4'd1;
                end else begin
                    if (r_win) begin
                        w_rdata1_nx = rom_d;
                        w_ack1_nx   = 1'b1;
                    end else begin
                        w_rdata0_nx = rom_d;
                        w_ack0_nx   = 1'b1;
                    end
                    w_strobe_n_nx = 1'b1;
                    w_last_nx     = r_win;
                    w_state_nx    = S_DONE;
                end
            end
            S_DONE: begin
                // rom_a is left alone so the address holds through recovery.
                w_state_nx = S_IDLE;
            end
            default: begin
                w_strobe_n_nx = 1'b1;
                w_state_nx    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_win      <= 1'b0;
            r_last     <= 1'b1;     // port 0 wins the first tie
            r_rom_a    <= '0;
            r_strobe_n <= 1'b1;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= 8'hFF;
            r_rdata1   <= 8'hFF;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_win      <= w_win_nx;
            r_last     <= w_last_nx;
            r_rom_a    <= w_rom_a_nx;
            r_strobe_n <= w_strobe_n_nx;
            r_ack0     <= w_ack0_nx;
            r_ack1     <= w_ack1_nx;
            r_rdata0   <= w_rdata0_nx;
            r_rdata1   <= w_rdata1_nx;
        end
    end

    // ce_n and oe_n always move together, so one register drives both pins.
    assign rom_a    = r_rom_a;
    assign rom_ce_n = r_strobe_n;
    assign rom_oe_n = r_strobe_n;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
// Self-checking bench for rom_arbiter. A timeline reference model (grant edge,
// access length, earliest next grant) predicts every output after every edge
// for the WAIT_CYCLES=3 instance; directed sequences and a vector table cover
// latency, fairness, reset and a second WAIT_CYCLES=1 instance.
module tb_rom_arbiter;

    localparam int W  = 3;
    localparam int AW = 19;

    logic          clk;
    logic          rst_n;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          ack0, ack1;
    logic [7:0]    rdata0, rdata1;
    logic [AW-1:0] rom_a;
    logic [7:0]    rom_d;
    logic          rom_ce_n, rom_oe_n, busy;

    logic          req0_b, req1_b;
    logic [AW-1:0] addr0_b, addr1_b;
    logic          ack0_b, ack1_b;
    logic [7:0]    rdata0_b, rdata1_b;
    logic [AW-1:0] rom_a_b;
    logic [7:0]    rom_d_b;
    logic          rom_ce_n_b, rom_oe_n_b, busy_b;

    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
        case (a)
            19'h12345: return 8'hA5;
            19'h00010: return 8'h11;
            19'h7FFFF: return 8'h22;
            default:   return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
        endcase
    endfunction

    assign rom_d   = rom_fn(rom_a);
    assign rom_d_b = rom_fn(rom_a_b);

    rom_arbiter #(.WAIT_CYCLES(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1),
        .rom_a(rom_a), .rom_d(rom_d), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
        .busy(busy)
    );

    rom_arbiter #(.WAIT_CYCLES(1), .AW(AW)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0(req0_b), .addr0(addr0_b), .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1_b), .addr1(addr1_b), .ack1(ack1_b), .rdata1(rdata1_b),
        .rom_a(rom_a_b), .rom_d(rom_d_b), .rom_ce_n(rom_ce_n_b), .rom_oe_n(rom_oe_n_b),
        .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a grant at edge g keeps strobes low after edges g..g+W-1,
    // raises ack after edge g+W, and the next grant can be taken at g+W+2.
    int            e;
    int            m_g, m_free, m_win, m_last;
    bit            m_active;
    logic [AW-1:0] m_a;
    logic [7:0]    m_rd [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_last   = 1;
        m_a      = '0;
        m_rd[0]  = 8'hFF;
        m_rd[1]  = 8'hFF;
        m_free   = 0;
    endtask

    task automatic compare_all();
        bit low, ackw, bsy;
        low  = m_active && (e >= m_g) && (e < m_g + W);
        ackw = m_active && (e == m_g + W);
        bsy  = m_active && (e >= m_g) && (e <= m_g + W);
        chk("rom_ce_n", 32'(rom_ce_n), 32'(!low));
        chk("rom_oe_n", 32'(rom_oe_n), 32'(!low));
        chk("rom_a",    32'(rom_a),    32'(m_a));
        chk("ack0",     32'(ack0),     32'(ackw && m_win == 0));
        chk("ack1",     32'(ack1),     32'(ackw && m_win == 1));
        chk("rdata0",   32'(rdata0),   32'(m_rd[0]));
        chk("rdata1",   32'(rdata1),   32'(m_rd[1]));
        chk("busy",     32'(busy),     32'(bsy));
    endtask

    task automatic cycle();
        logic          s_r0, s_r1;
        logic [AW-1:0] s_a0, s_a1;
        s_r0 = req0; s_r1 = req1; s_a0 = addr0; s_a1 = addr1;
        @(posedge clk);
        e++;
        if (rst_n) begin
            if (e >= m_free && (s_r0 || s_r1)) begin
                m_win    = (s_r0 && s_r1) ? 1 - m_last : (s_r1 ? 1 : 0);
                m_g      = e;
                m_a      = (m_win == 1) ? s_a1 : s_a0;
                m_free   = e + W + 2;
                m_active = 1'b1;
            end
            if (m_active && e == m_g + W) begin
                m_rd[m_win] = rom_fn(m_a);
                m_last      = m_win;
            end
        end else begin
            model_reset();
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_ack(input int p, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                at = e;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack%0d_wait: got no ack expected ack within %0d cycles", p, budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int at, prev, g;
        int ack_port [$];
        int ack_edge [$];

        tbl[0] = '{0, 19'h12345, 8'hA5};
        tbl[1] = '{1, 19'h7FFFF, 8'h22};
        tbl[2] = '{0, 19'h00010, 8'h11};
        tbl[3] = '{1, 19'h00000, 8'h00};
        tbl[4] = '{0, 19'h00002, 8'h02};
        tbl[5] = '{1, 19'h12345, 8'hA5};

        e = 0; m_g = 0; m_win = 0;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
        req0_b = 0; req1_b = 0; addr0_b = '0; addr1_b = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        do_reset();
        chk("reset_rdata0", 32'(rdata0), 32'h0FF);
        chk("reset_ce_n",   32'(rom_ce_n), 32'h1);

        // Back-to-back on port 1, new address presented right after each ack.
        req1 = 1; addr1 = 19'h0;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            wait_ack(1, 20, at);
            if (k > 0) chk("b2b_spacing", 32'(at - prev), 32'(W + 2));
            chk("b2b_rdata1", 32'(rdata1), 32'(k));
            prev = at;
            if (k < 2) addr1 = 19'(k + 1);
            else       req1  = 0;
        end
        chk("b2b_rdata0", 32'(rdata0), 32'h0FF);
        cycle(); cycle();

        // Simultaneous requests straight out of reset.
        do_reset();
        req0 = 1; addr0 = 19'h00010;
        req1 = 1; addr1 = 19'h7FFFF;
        g = e + 1;
        wait_ack(0, 20, at);
        chk("sim_ack0_lat", 32'(at - g), 32'(W));
        chk("sim_rdata0", 32'(rdata0), 32'h11);
        req0 = 0;
        wait_ack(1, 20, at);
        chk("sim_ack1_lat", 32'(at - g), 32'(2 * W + 2));
        chk("sim_rdata1", 32'(rdata1), 32'h22);
        req1 = 0;
        cycle(); cycle();

        // Fairness with both requests held for six accesses.
        req0 = 1; addr0 = 19'h00100;
        req1 = 1; addr1 = 19'h00200;
        for (int i = 0; i < 60 && ack_port.size() < 6; i++) begin
            cycle();
            if (ack0) begin ack_port.push_back(0); ack_edge.push_back(e); end
            if (ack1) begin ack_port.push_back(1); ack_edge.push_back(e); end
        end
        req0 = 0; req1 = 0;
        chk("fair_count", 32'(ack_port.size()), 32'd6);
        for (int i = 0; i < ack_port.size(); i++) begin
            chk("fair_order", 32'(ack_port[i]), 32'(i % 2));
            if (i > 0) chk("fair_period", 32'(ack_edge[i] - ack_edge[i-1]), 32'(W + 2));
        end
        cycle(); cycle();

        // Table of single accesses.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].port == 0) begin req0 = 1; addr0 = tbl[i].addr; end
            else                  begin req1 = 1; addr1 = tbl[i].addr; end
            g = e + 1;
            wait_ack(tbl[i].port, 20, at);
            chk("tbl_latency", 32'(at - g), 32'(W));
            chk("tbl_data", 32'((tbl[i].port == 0) ? rdata0 : rdata1), 32'(tbl[i].data));
            req0 = 0; req1 = 0;
            cycle(); cycle();
        end

        // Reset in the second cycle of an access.
        req0 = 1; addr0 = 19'h00003;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ce_n", 32'(rom_ce_n), 32'h1);
        chk("rst_mid_oe_n", 32'(rom_oe_n), 32'h1);
        chk("rst_mid_rdata0", 32'(rdata0), 32'h0FF);
        chk("rst_mid_ack0", 32'(ack0), 32'h0);
        model_reset();
        compare_all();
        cycle(); cycle();
        rst_n = 1'b1;
        addr0 = 19'h12345;
        g = e + 1;
        wait_ack(0, 20, at);
        chk("rst_after_lat", 32'(at - g), 32'(W));
        chk("rst_after_data", 32'(rdata0), 32'h0A5);
        req0 = 0;
        cycle(); cycle();

        // WAIT_CYCLES=1 instance.
        req0_b = 1; addr0_b = 19'h12345;
        cycle();
        chk("w1_e0_ce_n", 32'(rom_ce_n_b), 32'h0);
        chk("w1_e0_oe_n", 32'(rom_oe_n_b), 32'h0);
        chk("w1_e0_ack0", 32'(ack0_b), 32'h0);
        chk("w1_e0_busy", 32'(busy_b), 32'h1);
        cycle();
        chk("w1_e1_ce_n", 32'(rom_ce_n_b), 32'h1);
        chk("w1_e1_ack0", 32'(ack0_b), 32'h1);
        chk("w1_e1_rdata0", 32'(rdata0_b), 32'h0A5);
        chk("w1_e1_rdata1", 32'(rdata1_b), 32'h0FF);
        addr0_b = 19'h00001;
        cycle();
        chk("w1_e2_ack0", 32'(ack0_b), 32'h0);
        chk("w1_e2_busy", 32'(busy_b), 32'h0);
        chk("w1_e2_ce_n", 32'(rom_ce_n_b), 32'h1);
        cycle();
        chk("w1_e3_ce_n", 32'(rom_ce_n_b), 32'h0);
        chk("w1_e3_rom_a", 32'(rom_a_b), 32'h00001);
        req0_b = 0;
        cycle();
        chk("w1_e4_ack0", 32'(ack0_b), 32'h1);
        chk("w1_e4_rdata0", 32'(rdata0_b), 32'h01);
        chk("w1_e4_ack1", 32'(ack1_b), 32'h0);
        cycle(); cycle();

        // Random protocol-legal traffic against the timeline model.
        for (int i = 0; i < 800; i++) begin
            if (req0 && ack0) begin
                if ($urandom_range(1, 0) == 0) req0 = 0;
                else addr0 = 19'($urandom);
            end else if (!req0 && $urandom_range(9, 0) < 4) begin
                req0 = 1; addr0 = 19'($urandom);
            end
            if (req1 && ack1) begin
                if ($urandom_range(1, 0) == 0) req1 = 0;
                else addr1 = 19'($urandom);
            end else if (!req1 && $urandom_range(9, 0) < 4) begin
                req1 = 1;
                addr1 = ($urandom_range(3, 0) == 0) ? 19'h7FFFF : 19'($urandom);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single asynchronous 512 KB boot/data ROM between two synchronous requesters: port 0 (Z80 fetch path) and port 1 (loader/DMA path).
- Drives the ROM address, ce_n and oe_n, and inserts a programmable number of access wait cycles.
- Registers the returned byte into the winning port's read-data register and pulses that port's ack.
- Sits between the bus/DMA logic and the ROM chip pins.

Parameters:
WAIT_CYCLES, 3, clock cycles with ce_n/oe_n low per access; legal range 1..15.
AW, 19, ROM address width.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
req0  in  1  port 0 read request; level, held until ack0.
addr0  in  AW  port 0 address; stable while req0 is high.
ack0  out  1  one-cycle pulse; rdata0 is valid from this cycle.
rdata0  out  8  port 0 read data; holds until the next ack0.
req1  in  1  port 1 read request; same rules as req0.
addr1  in  AW  port 1 address.
ack1  out  1  port 1 completion pulse.
rdata1  out  8  port 1 read data.
rom_a  out  AW  ROM address pins.
rom_d  in  8  ROM data pins.
rom_ce_n  out  1  ROM chip enable, active low.
rom_oe_n  out  1  ROM output enable, active low.
busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - rom_ce_n=1, rom_oe_n=1, rom_a=0.
  - ack0=ack1=0, rdata0=rdata1=8'hFF, busy=0.
  - state=IDLE; the last-grant pointer is set so that port 0 wins the first tie.
- All outputs are registered. No combinational path from req to the ROM pins.
- States: IDLE, ACCESS, DONE.
- IDLE, at an edge where req0 or req1 is sampled high:
  - Choose the winner. If only one request is present, that port wins. If both are present, the port not granted last wins (round-robin).
  - Load rom_a from the winner's address. Drive rom_ce_n=0 and rom_oe_n=0.
  - Load cnt=WAIT_CYCLES-1, record the winner, go to ACCESS.
- ACCESS:
  - If cnt is not 0: decrement cnt.
  - If cnt is 0: latch rom_d into the winner's rdata, raise the winner's ack, drive rom_ce_n=rom_oe_n=1, update the last-grant pointer, go to DONE.
- DONE:
  - Lasts one cycle. ack is high only in this cycle and ROM strobes are high.
  - At the next edge: ack goes to 0 and state goes to IDLE.
  - rom_a holds its value through DONE.
- Latency: with req sampled at edge N, strobes are low for exactly WAIT_CYCLES cycles, N+1 through N+WAIT_CYCLES.
  - ack is high from edge N+WAIT_CYCLES to edge N+WAIT_CYCLES+1.
  - Earliest next grant is at edge N+WAIT_CYCLES+2.
  - Throughput is one access per WAIT_CYCLES+2 cycles.
- Requester rule:
  - After seeing ack at an edge, the requester drops req or presents a new address before the next edge.
  - A req still high in IDLE is a new request.
- Strobe recovery: DONE guarantees at least one cycle with ce_n high between consecutive accesses.
- The losing requester keeps its req high and is served next. No request is ever dropped.
- req falling during ACCESS is an illegal protocol. The access still completes and acks normally.
- Only one ack is ever high at a time. rdata of the non-winning port is unchanged.
- Reset during ACCESS or DONE:
  - Strobes deassert immediately (asynchronous). No ack is issued and rdata is set to FF.
  - After rst_n rises, the next access starts from IDLE.
- The counter is 4 bits wide. WAIT_CYCLES=1 gives cnt=0 on entry, so ACCESS lasts one cycle.

Test Plan:
1. Single port 0 read. WAIT_CYCLES=3, rom model holds 8'hA5 at 19'h12345, req0 with addr0=19'h12345 sampled at edge 0 -> rom_ce_n and rom_oe_n low for cycles 1-3, rom_a=12345, ack0 high for cycle 4 only, rdata0=A5, ack1 never high.
2. Simultaneous requests from reset. req0 (addr 0x00010→8'h11) and req1 (addr 0x7FFFF→8'h22) both held high -> port 0 served first (ack0, 11). Port 1 granted at edge 5 (ack1, 22). Strobes high in cycle 4 between the two accesses.
3. Fairness. Both requests held continuously for 6 accesses -> grants strictly alternate 0,1,0,1,0,1; period is 5 cycles.
4. Back-to-back on one port. Port 1 issues addr 0,1,2 (data 8'h00,8'h01,8'h02), each new address presented right after ack -> three ack1 pulses spaced 5 cycles apart, rdata1 = 00, 01, 02, rdata0 stays FF.
5. Reset mid-access. rst_n driven low in cycle 2 of an ACCESS -> rom_ce_n/oe_n go to 1 asynchronously, no ack, rdata=FF. After release, a fresh req0 completes normally.
6. WAIT_CYCLES=1. req0 sampled at edge 0 -> strobes low only in cycle 1, ack0 in cycle 2, next grant possible at edge 3.
